// File: rtl/reg_list_xfer.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_xfer
// Brief    : Multi-cycle PUSH/POP register-list transfer engine between the
//            decoder, register file and data memory. Optional PC pop is
//            enabled by defining REG_LIST_XFER_PC_POP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_list_xfer #(
    parameter int LIST_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [LIST_W-1:0] reg_list,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_read_addr,
    input  logic [31:0]       rf_read_data,
    output logic [3:0]        rf_write_addr,
    output logic [31:0]       rf_write_data,
    output logic              rf_write_enable,
    output logic              mem_req,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              pc_load,
    output logic [31:0]       pc_value
);

    localparam logic [3:0] C_SP_ADDR = 4'd13;
    localparam logic [3:0] C_LR_ADDR = 4'd14;
    localparam logic [3:0] C_HI_IDX  = 4'(LIST_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SP_READ = 3'd1,
        S_XFER    = 3'd2,
        S_SP_WB   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [LIST_W-1:0]  list_q, list_d;
    logic [3:0]         idx_q, idx_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [31:0]        new_sp_q, new_sp_d;
`ifdef REG_LIST_XFER_PC_POP_EN
    logic [31:0]        pc_value_q, pc_value_d;
    logic               pc_pop_q, pc_pop_d;
`endif

    logic [3:0]         w_count;
    logic [3:0]         w_first;
    logic [3:0]         w_next;
    logic               w_has_next;
    logic [31:0]        w_sp;
    logic [31:0]        w_span;

    // Population count plus lowest set bit and next set bit above idx_q.
    always_comb begin
        w_count    = '0;
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                w_count = w_count + 4'd1;
                w_first = 4'(i);
                if (i > int'(idx_q)) begin
                    w_next     = 4'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    assign w_sp   = {rf_read_data[31:2], 2'b00};
    assign w_span = {26'd0, w_count, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            list_q     <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            new_sp_q   <= '0;
`ifdef REG_LIST_XFER_PC_POP_EN
            pc_value_q <= '0;
            pc_pop_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            list_q     <= list_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            new_sp_q   <= new_sp_d;
`ifdef REG_LIST_XFER_PC_POP_EN
            pc_value_q <= pc_value_d;
            pc_pop_q   <= pc_pop_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        list_d          = list_q;
        idx_d           = idx_q;
        ptr_d           = ptr_q;
        new_sp_d        = new_sp_q;
`ifdef REG_LIST_XFER_PC_POP_EN
        pc_value_d      = pc_value_q;
        pc_pop_d        = pc_pop_q;
`endif
        busy            = (state_q != S_IDLE);
        done            = 1'b0;
        rf_read_addr    = '0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_write_enable = 1'b0;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    list_d = reg_list;
`ifdef REG_LIST_XFER_PC_POP_EN
                    pc_pop_d = 1'b0;
`else
                    // Without PC pop support the top bit is dropped for POP.
                    if (op) begin
                        list_d[LIST_W-1] = 1'b0;
                    end
`endif
                    state_d = S_SP_READ;
                end
            end
            S_SP_READ: begin
                rf_read_addr = C_SP_ADDR;
                ptr_d        = op_q ? w_sp : w_sp - w_span;
                new_sp_d     = op_q ? w_sp + w_span : w_sp - w_span;
                idx_d        = w_first;
                state_d      = (w_count == 4'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                mem_req   = 1'b1;
                mem_write = ~op_q;
                mem_addr  = ptr_q;
                if (!op_q) begin
                    rf_read_addr = (idx_q == C_HI_IDX) ? C_LR_ADDR : idx_q;
                    mem_wdata    = rf_read_data;
                end else if (idx_q != C_HI_IDX) begin
                    rf_write_enable = mem_ready;
                    rf_write_addr   = idx_q;
                    rf_write_data   = mem_rdata;
                end
                if (mem_ready) begin
                    ptr_d = ptr_q + 32'd4;
                    idx_d = w_next;
`ifdef REG_LIST_XFER_PC_POP_EN
                    if (op_q && (idx_q == C_HI_IDX)) begin
                        pc_value_d = {mem_rdata[31:1], 1'b0};
                        pc_pop_d   = 1'b1;
                    end
`endif
                    if (!w_has_next) begin
                        state_d = S_SP_WB;
                    end
                end
            end
            S_SP_WB: begin
                rf_write_addr   = C_SP_ADDR;
                rf_write_data   = new_sp_q;
                rf_write_enable = 1'b1;
                state_d         = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef REG_LIST_XFER_PC_POP_EN
    assign pc_load  = (state_q == S_DONE) && pc_pop_q;
    assign pc_value = pc_value_q;
`else
    assign pc_load  = 1'b0;
    assign pc_value = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_list_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_list_xfer
// Brief    : Self-checking bench for reg_list_xfer with a register-file and
//            memory environment and a list-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_list_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [8:0]  reg_list;
    logic        busy;
    logic        done;
    logic [3:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pc_load;
    logic [31:0] pc_value;

    int errors = 0;
    int checks = 0;

    logic [31:0] regs [0:15];
    logic [31:0] mem  [0:1023];

    reg_list_xfer #(.LIST_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .reg_list(reg_list),
        .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc_load(pc_load), .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    assign rf_read_data = regs[rf_read_addr];
    assign mem_rdata    = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;
        if (mem_req && mem_ready && mem_write) mem[mem_addr[11:2]] <= mem_wdata;
    end

    // Runs one command and compares its bus traffic, timing and results
    // against the list-level expectations. mode: 0 ready=1, 1 random, 2 stall.
    task automatic run_cmd(input logic o, input logic [8:0] lst, input int mode, input int stall);
        logic [31:0] sp, base, nsp, a, w, exp_pc, sp_before, prev_addr, prev_wdata, got_pcv;
        logic [8:0]  eff;
        logic        exp_pcl, got_done, prev_wait, got_pcl;
        int          n, cyc, waits, stall_left, exp_cyc;
        logic [31:0] ea[$], ed[$], oa[$], od[$], erd[$], ord[$];
        logic [3:0]  era[$], ora[$];
        logic        ow[$];
        eff = lst;
`ifndef REG_LIST_XFER_PC_POP_EN
        if (o) eff[8] = 1'b0;
`endif
        sp_before = regs[13];
        sp   = {regs[13][31:2], 2'b00};
        n    = $countones(eff);
        base = o ? sp : sp - 32'(4 * n);
        nsp  = o ? sp + 32'(4 * n) : base;
        exp_pcl = 1'b0;
        exp_pc  = '0;
        a = base;
        for (int i = 0; i < 9; i++) begin
            if (eff[i]) begin
                ea.push_back(a);
                if (!o) begin
                    ed.push_back(i == 8 ? regs[14] : regs[i]);
                end else begin
                    w = mem[a[11:2]];
                    ed.push_back(w);
                    if (i < 8) begin
                        era.push_back(4'(i));
                        erd.push_back(w);
                    end else begin
                        exp_pcl = 1'b1;
                        exp_pc  = {w[31:1], 1'b0};
                    end
                end
                a = a + 32'd4;
            end
        end
        if (n > 0) begin
            era.push_back(4'd13);
            erd.push_back(nsp);
        end

        @(posedge clk); #1;
        start = 1'b1; op = o; reg_list = lst; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; waits = 0; stall_left = stall; got_done = 1'b0; prev_wait = 1'b0;
        got_pcl = 1'b0; got_pcv = '0; prev_addr = '0; prev_wdata = '0;
        while (!got_done && cyc < 200) begin
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = (stall_left == 0);
            endcase
            @(negedge clk);
            if (prev_wait) begin
                checks++;
                if (!mem_req || mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                    errors++;
                    $display("FAIL hold: got addr=%h wdata=%h req=%b want addr=%h wdata=%h req=1",
                             mem_addr, mem_wdata, mem_req, prev_addr, prev_wdata);
                end
            end
            prev_wait  = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            if (mem_req && !mem_ready) begin
                waits++;
                if (stall_left > 0) stall_left--;
            end
            if (mem_req && mem_ready) begin
                ow.push_back(mem_write);
                oa.push_back(mem_addr);
                od.push_back(mem_write ? mem_wdata : mem_rdata);
            end
            if (rf_write_enable) begin
                ora.push_back(rf_write_addr);
                ord.push_back(rf_write_data);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b want 1", cyc, busy);
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                got_pcl  = pc_load;
                got_pcv  = pc_value;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL timeout: got no done after %0d cycles want done", cyc);
        end
        exp_cyc = (n == 0) ? 2 : n + 3 + waits;
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL done_cycle: got %0d want %0d", cyc, exp_cyc);
        end
        checks++;
        if (got_pcl !== exp_pcl) begin
            errors++;
            $display("FAIL pc_load: got %b want %b", got_pcl, exp_pcl);
        end
`ifdef REG_LIST_XFER_PC_POP_EN
        if (exp_pcl) begin
`else
        begin
`endif
            checks++;
            if (got_pcv !== exp_pc) begin
                errors++;
                $display("FAIL pc_value: got %h want %h", got_pcv, exp_pc);
            end
        end
        checks++;
        if (oa.size() != ea.size() || ora.size() != era.size()) begin
            errors++;
            $display("FAIL counts: got mem=%0d rf=%0d want mem=%0d rf=%0d",
                     oa.size(), ora.size(), ea.size(), era.size());
        end
        for (int k = 0; k < oa.size() && k < ea.size(); k++) begin
            checks++;
            if (oa[k] !== ea[k] || od[k] !== ed[k] || ow[k] !== ~o) begin
                errors++;
                $display("FAIL xfer%0d: got w=%b addr=%h data=%h want w=%b addr=%h data=%h",
                         k, ow[k], oa[k], od[k], ~o, ea[k], ed[k]);
            end
        end
        for (int k = 0; k < ora.size() && k < era.size(); k++) begin
            checks++;
            if (ora[k] !== era[k] || ord[k] !== erd[k]) begin
                errors++;
                $display("FAIL rfwr%0d: got r%0d=%h want r%0d=%h", k, ora[k], ord[k], era[k], erd[k]);
            end
        end

        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_done: got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (regs[13] !== ((n > 0) ? nsp : sp_before)) begin
            errors++;
            $display("FAIL sp_final: got %h want %h", regs[13], (n > 0) ? nsp : sp_before);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, mem_req, mem_write, rf_write_enable, pc_load} !== 6'b0 ||
            {mem_addr, mem_wdata, rf_write_data, pc_value} !== 128'b0 ||
            {rf_read_addr, rf_write_addr} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%h want all 0",
                     busy, done, mem_req, mem_addr);
        end
    endtask

    task automatic test_push_example();
        regs[13] = 32'h1000; regs[0] = 32'hA; regs[1] = 32'hB; regs[14] = 32'hC;
        run_cmd(1'b0, 9'h103, 0, 0);
        checks++;
        if (mem[10'h3FD] !== 32'hA || mem[10'h3FE] !== 32'hB || mem[10'h3FF] !== 32'hC) begin
            errors++;
            $display("FAIL push_mem: got %h %h %h want a b c", mem[10'h3FD], mem[10'h3FE], mem[10'h3FF]);
        end
    endtask

    task automatic test_pop_example();
        regs[13] = 32'hFF4; regs[2] = 32'h0;
        mem[10'h3FD] = 32'h11; mem[10'h3FE] = 32'h23;
        run_cmd(1'b1, 9'h104, 0, 0);
        checks++;
        if (regs[2] !== 32'h11) begin
            errors++;
            $display("FAIL pop_r2: got %h want 00000011", regs[2]);
        end
    endtask

    task automatic test_wait_states();
        regs[13] = 32'h1800; regs[7] = 32'h7777_0007;
        run_cmd(1'b0, 9'h080, 2, 3);
    endtask

    task automatic test_empty();
        regs[13] = 32'h1402;
        run_cmd(1'b0, 9'h000, 0, 0);
        run_cmd(1'b1, 9'h000, 0, 0);
        run_cmd(1'b1, 9'h100, 0, 0);
    endtask

    task automatic test_wrap();
        regs[13] = 32'h0;
        for (int i = 0; i < 8; i++) regs[i] = 32'hC0DE_0000 + 32'(i);
        run_cmd(1'b0, 9'h0FF, 0, 0);
        regs[13] = 32'hFFFF_FFF8;
        run_cmd(1'b1, 9'h003, 1, 0);
    endtask

    task automatic test_reset_mid();
        regs[13] = 32'h2000; regs[0] = 32'hDEAD_0001; regs[1] = 32'hDEAD_0002; regs[2] = 32'hDEAD_0003;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; reg_list = 9'h007; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req: got %b want 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_req, mem_write, rf_write_enable, pc_load} !== 6'b0 ||
            {mem_addr, mem_wdata, rf_write_data, pc_value} !== 128'b0 ||
            {rf_read_addr, rf_write_addr} !== 8'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b req=%b addr=%h wdata=%h pc=%h want all 0",
                     busy, mem_req, mem_addr, mem_wdata, pc_value);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (regs[13] !== 32'h2000) begin
            errors++;
            $display("FAIL mid_reset_sp: got %h want 00002000", regs[13]);
        end
        run_cmd(1'b0, 9'h007, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        regs[13] = 32'h1C00;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; reg_list = 9'h011; mem_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 12) start = 1'b0;
            @(negedge clk);
            exp_busy = (c != 6) && (c != 12);
            exp_done = (c == 5) || (c == 11);
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                errors++;
                $display("FAIL b2b cycle %0d: got busy=%b done=%b want busy=%b done=%b",
                         c, busy, done, exp_busy, exp_done);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (regs[13] !== 32'h1BF0) begin
            errors++;
            $display("FAIL b2b_sp: got %h want 00001bf0", regs[13]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            regs[13] = 32'h1000 + 32'(4 * $urandom_range(16, 200)) + 32'($urandom_range(0, 3));
            for (int i = 0; i < 1024; i++) mem[i] = $urandom;
            run_cmd(1'($urandom_range(0, 1)), 9'($urandom), 1, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; reg_list = '0; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        test_reset();
        #1 rst = 1'b0;
        test_reset();
        test_push_example();
        test_pop_example();
        test_reset_mid();
        test_wait_states();
        test_empty();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_list_xfer.md
# reg_list_xfer

Multi-cycle register-list transfer engine for the Cortex-M0 core, executing PUSH (store-multiple, decrement-before, SP writeback) and POP (load-multiple, increment-after, SP writeback). It sits between the decoder and the register file: it reads registers through a register-file read port, drives its write port, and talks to the data memory through a req/ready handshake. PC is never written through the register file. POP into PC is delivered to the fetch unit through a separate load strobe.

## Interface
Parameters:
- LIST_W, 9, width of the register list: bits 0-7 select R0-R7; bit 8 selects LR for PUSH and PC for POP.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = PUSH, 1 = POP.
- reg_list  in  LIST_W  register selection; latched on the accepted start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- rf_read_addr  out  4  register-file read address.
- rf_read_data  in  32  combinational read data for rf_read_addr.
- rf_write_addr  out  4  register-file write address.
- rf_write_data  out  32  register-file write data.
- rf_write_enable  out  1  register-file write strobe.
- mem_req  out  1  memory request.
- mem_write  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  store data.
- mem_ready  in  1  the transfer completes on the rising edge where mem_req and mem_ready are both high.
- mem_rdata  in  32  load data; valid when mem_ready is high.
- pc_load  out  1  one-cycle strobe to the fetch unit.
- pc_value  out  32  new PC value.

## Operation
- States: IDLE, SP_READ, XFER, SP_WB, DONE.
- IDLE: on start=1, latch op and reg_list, then go to SP_READ. A start in any other state is ignored.
- SP_READ (1 cycle):
  - Drive rf_read_addr=13 and latch SP as {rf_read_data[31:2],2'b00}.
  - Compute N = popcount of the effective list.
  - PUSH: base = SP - 4N and new SP = base.
  - POP: base = SP and new SP = SP + 4N.
  - If N=0, go to DONE. Otherwise go to XFER.
- XFER:
  - Registers are transferred in ascending order (R0..R7, then bit 8) to ascending addresses base, base+4, and so on.
  - mem_req, mem_write, mem_addr and mem_wdata are held stable until mem_ready is high. The pointer and register index advance on the accepting edge.
  - PUSH: rf_read_addr = current register (14 for bit 8); mem_wdata = rf_read_data (combinational path).
  - POP to R0-R7: rf_write_enable = mem_ready in the same cycle; rf_write_addr = register; rf_write_data = mem_rdata.
  - POP of bit 8: capture {mem_rdata[31:1],1'b0} into pc_value; no register-file write.
  - After the last transfer is accepted, go to SP_WB.
- SP_WB (1 cycle): rf_write_addr=13, rf_write_data = new SP, rf_write_enable=1. Then go to DONE.
- DONE (1 cycle): done=1. pc_load=1 if a PC pop occurred. Then go to IDLE.
- Outside the cases above, rf_write_enable, mem_req and pc_load are 0.
- Reset (any time, including mid-transfer):
  - state=IDLE.
  - busy, done, mem_req, mem_write, rf_write_enable and pc_load = 0.
  - All addresses, data and pc_value = 0.
  - An in-flight memory request is abandoned; the memory side must tolerate the dropped req.
- Arithmetic is 32-bit modulo: a PUSH from SP=0x0 wraps to 0xFFFFFFxx with no error.

## Timing
- The start edge is E0. SP_READ is cycle 1. With mem_ready tied high, transfer k (k=0..N-1) occupies cycle 2+k, SP_WB is cycle N+2 and done is in cycle N+3.
- Each wait cycle (mem_ready=0) adds one cycle.
- N=0: done in cycle 2; no memory access and no SP write.
- start may be re-asserted in the cycle after done; it is accepted on the next edge.

## Configuration
- REG_LIST_XFER_PC_POP_EN defined: POP with bit 8 set loads PC as described above (counted in N, pc_load pulses in DONE).
- REG_LIST_XFER_PC_POP_EN not defined: on POP, bit 8 is ignored (not counted, not transferred); pc_load and pc_value are tied to 0. PUSH of LR is unaffected.

## Test plan
- Reset mid-XFER of a 3-register PUSH -> all outputs 0 in the same cycle; next start behaves normally.
- SP=0x1000, R0=0xA, R1=0xB, LR=0xC, PUSH list 0x103, ready=1:
  - Stores 0xA@0xFF4, 0xB@0xFF8, 0xC@0xFFC in cycles 2-4.
  - SP write 0xFF4 in cycle 5; done in cycle 6.
- SP=0xFF4, memory 0xFF4=0x11, 0xFF8=0x23 (0xFF8 holds the PC word), POP list 0x104, ready=1:
  - R2=0x11.
  - SP write 0xFFC.
  - done with pc_load=1 and pc_value=0x22; with the macro undefined, N=1, SP=0xFF8 and pc_load=0.
- PUSH {R7} with mem_ready low for 3 cycles -> mem_addr and mem_wdata held constant for 4 cycles; done in cycle 7.
- Empty list, either op -> no mem_req, no rf_write_enable; done in cycle 2; SP unchanged.
- start held high through done -> a second command starts only after returning to IDLE; no start is accepted while busy.
